// File: rtl/burst_read_mode.sv
// Clock-burst read master for a 3-wire serial RTC (CE / SCLK / IO).
// Sends the burst-read command LSB-first, turns IO around and shifts in NUM_BYTES bytes.
module burst_read_mode #(
  parameter int unsigned HALF      = 2,
  parameter logic [7:0]  CMD_BYTE  = 8'hBF,
  parameter int unsigned NUM_BYTES = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     read,
  input  logic                     io_in,
  output logic                     ce,
  output logic                     sclk,
  output logic                     io_out,
  output logic                     io_oe,
  output logic                     busy,
  output logic                     valid,
  output logic [8*NUM_BYTES-1:0]   rtc_data
);

  localparam int unsigned BIT_CYC = 2 * HALF;
  localparam int unsigned TW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int unsigned NBITS   = 8 * NUM_BYTES;
  localparam int unsigned BW      = ($clog2(NBITS) > 3) ? $clog2(NBITS) : 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    CMD   = 3'd2,
    READ  = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [NBITS-1:0]   shift_q, shift_d;
  logic [NBITS-1:0]   rtc_data_q, rtc_data_d;
  logic               ce_q, ce_d;
  logic               sclk_q, sclk_d;
  logic               io_out_q, io_out_d;
  logic               io_oe_q, io_oe_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               bit_end_c;
  logic               rise_c;

  // Last clk cycle of a bit period, and the cycle before sclk rises.
  assign bit_end_c = (tick_q == TW'(BIT_CYC - 1));
  assign rise_c    = (tick_q == TW'(HALF - 1));

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rtc_data_q <= '0;
      ce_q       <= 1'b0;
      sclk_q     <= 1'b0;
      io_out_q   <= 1'b0;
      io_oe_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rtc_data_q <= rtc_data_d;
      ce_q       <= ce_d;
      sclk_q     <= sclk_d;
      io_out_q   <= io_out_d;
      io_oe_q    <= io_oe_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  // Next state, counters and shift register.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rtc_data_d = rtc_data_q;

    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (!read) state_d = SETUP;
      end
      SETUP: begin
        tick_d = tick_q + TW'(1);
        if (bit_end_c) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = CMD;
        end
      end
      CMD: begin
        tick_d = tick_q + TW'(1);
        if (bit_end_c) begin
          tick_d = '0;
          if (bit_q == BW'(7)) begin
            bit_d   = '0;
            state_d = READ;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      READ: begin
        // Sample on the clk edge that raises sclk; bit j ends up in shadow bit j.
        if (rise_c) shift_d = {io_in, shift_q[NBITS-1:1]};
        tick_d = tick_q + TW'(1);
        if (bit_end_c) begin
          tick_d = '0;
          if (bit_q == BW'(NBITS - 1)) begin
            bit_d   = '0;
            state_d = HOLD;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      HOLD: begin
        tick_d = tick_q + TW'(1);
        if (bit_end_c) begin
          tick_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        tick_d  = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
      default: begin
        tick_d  = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase

    if (state_d == DONE) rtc_data_d = shift_q;
  end

  // Pin values derive from the next state so every output is a flop with no decode glitches.
  always_comb begin
    ce_d     = (state_d == SETUP) || (state_d == CMD) || (state_d == READ) || (state_d == HOLD);
    sclk_d   = ((state_d == CMD) || (state_d == READ)) && (tick_d >= TW'(HALF));
    io_oe_d  = (state_d == CMD);
    io_out_d = (state_d == CMD) ? CMD_BYTE[bit_d[2:0]] : 1'b0;
    busy_d   = (state_d != IDLE);
    valid_d  = (state_d == DONE);
  end

  assign ce       = ce_q;
  assign sclk     = sclk_q;
  assign io_out   = io_out_q;
  assign io_oe    = io_oe_q;
  assign busy     = busy_q;
  assign valid    = valid_q;
  assign rtc_data = rtc_data_q;

endmodule

// File: tb/tb_burst_read_mode.sv
// Bench for burst_read_mode: a behavioural RTC slave drives IO, a timeline model
// of the burst provides the expected pin activity and frame contents.
module tb_burst_read_mode;

  localparam int unsigned HALF      = 2;
  localparam int unsigned NUM_BYTES = 8;
  localparam int unsigned NBITS     = 8 * NUM_BYTES;
  localparam logic [7:0]  CMD       = 8'hBF;
  localparam int unsigned BIT_CYC   = 2 * HALF;
  // CE covers setup bit, 8 command bits, all data bits and the hold bit.
  localparam int          CE_CYCLES = int'((1 + 8 + NBITS + 1) * BIT_CYC);

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              read = 1'b1;
  logic              io_in = 1'b0;
  logic              ce, sclk, io_out, io_oe, busy, valid;
  logic [NBITS-1:0]  rtc_data;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] rtc_frame = '0;
  int          fall_cnt  = 0;
  logic        last_ce   = 1'b0;

  always #5 clk = ~clk;

  burst_read_mode #(
    .HALF      (HALF),
    .CMD_BYTE  (CMD),
    .NUM_BYTES (NUM_BYTES)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .read     (read),
    .io_in    (io_in),
    .ce       (ce),
    .sclk     (sclk),
    .io_out   (io_out),
    .io_oe    (io_oe),
    .busy     (busy),
    .valid    (valid),
    .rtc_data (rtc_data)
  );

  // RTC slave: after the 8th falling sclk edge it presents data bit k after falling edge 8+k.
  always @(posedge ce or negedge ce or negedge sclk) begin
    if (ce && !last_ce) begin
      fall_cnt = 0;
      io_in    = 1'b0;
    end else if (!ce) begin
      io_in = 1'b0;
    end else begin
      fall_cnt++;
      if (fall_cnt >= 8 && fall_cnt < 8 + int'(NBITS)) io_in = rtc_frame[6'(fall_cnt - 8)];
      else io_in = 1'b0;
    end
    last_ce = ce;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Follows one burst from the read request to the cycle after valid.
  task automatic observe_burst(input string tag, input logic [63:0] exp_frame,
                               input logic [63:0] prev_data, input int release_at);
    int cyc = 0, wait_c = 0, idx = 0, ce_run = 0, rise = 0, fall = 0;
    int first_rise = -1, fall8 = -1, oe_fall = -1;
    int held_bad = 0, out_bad = 0, oe_bad = 0;
    logic p_sclk = 1'b0, p_oe = 1'b0, p_ce = 1'b0, seen_valid = 1'b0, valid_after_ce = 1'b0;
    logic [7:0]  cmd_obs = '0;
    logic [63:0] data_at_valid = '0;

    while (!ce && wait_c < 20) begin
      @(negedge clk);
      wait_c++; cyc++;
      if (cyc == release_at) read = 1'b1;
    end
    check({tag, "_start_gap"}, 64'(wait_c), 64'(1));

    while (!seen_valid && idx < 2 * CE_CYCLES) begin
      if (ce) ce_run++;
      if (sclk && !p_sclk) begin
        if (rise == 0) first_rise = idx;
        if (rise < 8) begin
          cmd_obs[rise[2:0]] = io_out;
          if (!io_oe) oe_bad++;
        end
        rise++;
      end
      if (!sclk && p_sclk) begin
        fall++;
        if (fall == 8) fall8 = idx;
      end
      if (!io_oe && p_oe && oe_fall < 0) oe_fall = idx;
      if (!io_oe && io_out) out_bad++;
      if (valid) begin
        seen_valid     = 1'b1;
        data_at_valid  = rtc_data;
        valid_after_ce = p_ce && !ce;
      end else if (rtc_data !== prev_data) begin
        held_bad++;
      end
      p_sclk = sclk; p_oe = io_oe; p_ce = ce;
      if (!seen_valid) begin
        @(negedge clk);
        idx++; cyc++;
        if (cyc == release_at) read = 1'b1;
      end
    end

    check({tag, "_valid_seen"},     64'(seen_valid), 64'(1));
    check({tag, "_ce_cycles"},      64'(ce_run), 64'(CE_CYCLES));
    check({tag, "_first_rise"},     64'(first_rise), 64'(BIT_CYC + HALF));
    check({tag, "_cmd_bits"},       64'(cmd_obs), 64'(CMD));
    check({tag, "_cmd_oe"},         64'(oe_bad), 64'(0));
    check({tag, "_sclk_rises"},     64'(rise), 64'(8 + NBITS));
    check({tag, "_cmd7_fall_idx"},  64'(fall8), 64'((1 + 8) * BIT_CYC));
    check({tag, "_oe_fall_idx"},    64'(oe_fall), 64'((1 + 8) * BIT_CYC));
    check({tag, "_io_out_released"}, 64'(out_bad), 64'(0));
    check({tag, "_data_held"},      64'(held_bad), 64'(0));
    check({tag, "_valid_after_ce"}, 64'(valid_after_ce), 64'(1));
    check({tag, "_frame"},          data_at_valid, exp_frame);

    @(negedge clk);
    cyc++;
    if (cyc == release_at) read = 1'b1;
    check({tag, "_valid_one_cycle"}, 64'(valid), 64'(0));
    check({tag, "_frame_kept"},      rtc_data, exp_frame);
  endtask

  task automatic expect_idle(input string tag, input int n);
    int hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (ce || busy) hi++;
    end
    check(tag, 64'(hi), 64'(0));
  endtask

  initial begin
    logic [63:0] last_frame, f, f2;
    int r;
    logic ps;

    // Reset
    #8;
    check("rst_ce",    64'(ce), 64'(0));
    check("rst_sclk",  64'(sclk), 64'(0));
    check("rst_io_oe", 64'(io_oe), 64'(0));
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_busy",  64'(busy), 64'(0));
    check("rst_data",  rtc_data, 64'h0);
    #2 rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Fixed frame, single-cycle read pulse
    rtc_frame = 64'h8024030625123045;
    read = 1'b0;
    observe_burst("b1", 64'h8024030625123045, 64'h0, 1);
    last_frame = 64'h8024030625123045;
    expect_idle("b1_idle", 10);

    // Read held low for part of the burst: still exactly one burst
    f = {$urandom, $urandom};
    rtc_frame = f;
    read = 1'b0;
    observe_burst("b2", f, last_frame, int'($urandom_range(20, 250)));
    last_frame = f;
    expect_idle("b2_idle", 10);

    // Read held low across two bursts: back-to-back, first frame held until second valid
    f  = {$urandom, $urandom};
    f2 = {$urandom, $urandom};
    rtc_frame = f;
    read = 1'b0;
    observe_burst("b3a", f, last_frame, 0);
    rtc_frame = f2;
    observe_burst("b3b", f2, f, 1);
    last_frame = f2;
    expect_idle("b3_idle", 10);

    // Reset after 20 data bits of a burst
    f = {$urandom, $urandom};
    rtc_frame = f;
    read = 1'b0;
    @(negedge clk);
    read = 1'b1;
    r  = 0;
    ps = sclk;
    for (int i = 0; i < 2 * CE_CYCLES && r < 28; i++) begin
      @(negedge clk);
      if (sclk && !ps) r++;
      ps = sclk;
    end
    check("mid_rst_reached", 64'(r), 64'(28));
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_ce",     64'(ce), 64'(0));
    check("mid_rst_sclk",   64'(sclk), 64'(0));
    check("mid_rst_io_oe",  64'(io_oe), 64'(0));
    check("mid_rst_io_out", 64'(io_out), 64'(0));
    check("mid_rst_busy",   64'(busy), 64'(0));
    check("mid_rst_data",   rtc_data, 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    f = {$urandom, $urandom};
    rtc_frame = f;
    read = 1'b0;
    observe_burst("b4", f, 64'h0, 1);
    last_frame = f;

    // A few more random frames with random pulse widths
    for (int k = 0; k < 2; k++) begin
      repeat ($urandom_range(1, 6)) @(negedge clk);
      f = {$urandom, $urandom};
      rtc_frame = f;
      read = 1'b0;
      observe_burst($sformatf("r%0d", k), f, last_frame, int'($urandom_range(1, 5)));
      last_frame = f;
    end
    expect_idle("end_idle", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
